ahb_arbiter_slave: RTL and testbench

- Per-slave arbiter in the AHB interconnect. It sits directly upstream of the slave-side payload mux and drives that mux's one-hot select.
- It chooses one of CHANNEL_NUM requesting masters using round-robin, and holds the grant for a whole burst.
- It also produces a registered data-phase select for the write-data/response path.
- Unselected channels read as zero, so an empty grant presents an IDLE transfer to the slave.

---
 rtl/ahb_arbiter_slave_pkg.sv | 41 ++++
 rtl/ahb_arbiter_slave_rr_picker.sv | 33 +++
 rtl/ahb_arbiter_slave.sv | 137 +++++++++++++
 tb/tb_ahb_arbiter_slave.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arbiter_slave_pkg.sv
// Shared AHB transfer/burst encodings and the arbiter state type.
// Used by the per-slave round-robin arbiter.
package AHB_package;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    // Beat count of a fixed-length burst; undefined-length INCR reports 0.
    function automatic logic [4:0] burst_beats(input hburst_t b);
        logic [4:0] n;
        case (b)
            HBURST_SINGLE:                n = 5'd1;
            HBURST_WRAP4,  HBURST_INCR4:  n = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  n = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: n = 5'd16;
            default:                      n = 5'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ahb_arbiter_slave_rr_picker.sv
// Combinational round-robin search: first requester after last_ptr, wrapping.
// Reports the winner both one-hot and as a binary index.
module ahb_rr_picker #(
    parameter int CHANNEL_NUM = 2,
    parameter int ID_W        = 1
) (
    input  logic [CHANNEL_NUM-1:0] req,
    input  logic [ID_W-1:0]        last_ptr,
    output logic [CHANNEL_NUM-1:0] winner,
    output logic [ID_W-1:0]        winner_id,
    output logic                   any_req
);

    logic [ID_W-1:0] idx;

    always_comb begin
        winner    = '0;
        winner_id = '0;
        any_req   = 1'b0;
        idx       = '0;
        for (int i = 1; i <= CHANNEL_NUM; i++) begin
            idx = ID_W'((int'(last_ptr) + i) % CHANNEL_NUM);
            if (!any_req && req[idx]) begin
                any_req   = 1'b1;
                winner_id = idx;
            end
        end
        if (any_req) begin
            winner[winner_id] = 1'b1;
        end
    end

endmodule

// File: rtl/ahb_arbiter_slave.sv
// Per-slave AHB arbiter: round-robin grant held for a whole burst, plus a
// registered data-phase owner select for the write-data/response path.
module ahb_arbiter_slave
    import AHB_package::*;
#(
    parameter int CHANNEL_NUM = 2,
    parameter int ID_W        = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [CHANNEL_NUM-1:0]   hreq,
    input  logic [2*CHANNEL_NUM-1:0] htrans_in,
    input  logic [3*CHANNEL_NUM-1:0] hburst_in,
    input  logic                     hready_in,
    output logic [CHANNEL_NUM-1:0]   sel,
    output logic [CHANNEL_NUM-1:0]   sel_data,
    output logic [ID_W-1:0]          master_id,
    output logic                     grant_valid
);

    logic [1:0] htrans_arr [CHANNEL_NUM];
    logic [2:0] hburst_arr [CHANNEL_NUM];

    generate
        for (genvar gi = 0; gi < CHANNEL_NUM; gi++) begin : g_unpack
            assign htrans_arr[gi] = htrans_in[gi*2 +: 2];
            assign hburst_arr[gi] = hburst_in[gi*3 +: 3];
        end
    endgenerate

    logic [CHANNEL_NUM-1:0] sel_reg;
    logic [CHANNEL_NUM-1:0] sel_data_reg;
    logic [ID_W-1:0]        master_id_reg;
    logic                   grant_valid_reg;
    logic [ID_W-1:0]        last_ptr_reg;
    logic [3:0]             beats_left_reg;
    logic                   incr_mode_reg;
    arb_state_t             state_reg;

    logic [CHANNEL_NUM-1:0] pick_onehot;
    logic [ID_W-1:0]        pick_id;
    logic                   pick_any;

    ahb_rr_picker #(
        .CHANNEL_NUM (CHANNEL_NUM),
        .ID_W        (ID_W)
    ) u_picker (
        .req       (hreq),
        .last_ptr  (last_ptr_reg),
        .winner    (pick_onehot),
        .winner_id (pick_id),
        .any_req   (pick_any)
    );

    htrans_t    cur_trans;
    hburst_t    cur_burst;
    logic       cur_req;
    logic       release_now;
    logic [3:0] beats_left_next;
    logic       incr_mode_next;

    assign cur_trans = htrans_t'(htrans_arr[master_id_reg]);
    assign cur_burst = hburst_t'(hburst_arr[master_id_reg]);
    assign cur_req   = hreq[master_id_reg];

    // Decide, for the current owner, whether this edge ends its tenure.
    always_comb begin
        release_now     = 1'b0;
        beats_left_next = beats_left_reg;
        incr_mode_next  = incr_mode_reg;
        if (state_reg == ARB_OWNED) begin
            if (incr_mode_reg && !cur_req &&
                (cur_trans == HTRANS_IDLE || cur_trans == HTRANS_NONSEQ)) begin
                release_now = 1'b1;
            end else begin
                case (cur_trans)
                    HTRANS_IDLE: release_now = 1'b1;
                    HTRANS_BUSY: ;
                    HTRANS_NONSEQ: begin
                        if (cur_burst == HBURST_SINGLE) begin
                            release_now = 1'b1;
                        end else if (cur_burst == HBURST_INCR) begin
                            incr_mode_next  = 1'b1;
                            beats_left_next = 4'd0;
                        end else begin
                            incr_mode_next  = 1'b0;
                            beats_left_next = 4'(burst_beats(cur_burst) - 5'd1);
                        end
                    end
                    HTRANS_SEQ: begin
                        // A stray SEQ at zero saturates instead of wrapping.
                        if (!incr_mode_reg && beats_left_reg != 4'd0) begin
                            beats_left_next = beats_left_reg - 4'd1;
                            release_now     = (beats_left_reg == 4'd1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_reg         <= '0;
            sel_data_reg    <= '0;
            master_id_reg   <= '0;
            grant_valid_reg <= 1'b0;
            last_ptr_reg    <= ID_W'(CHANNEL_NUM - 1);
            beats_left_reg  <= 4'd0;
            incr_mode_reg   <= 1'b0;
            state_reg       <= ARB_IDLE;
        end else if (hready_in) begin
            sel_data_reg <= sel_reg;
            if (state_reg == ARB_IDLE || release_now) begin
                sel_reg         <= pick_onehot;
                master_id_reg   <= pick_id;
                grant_valid_reg <= pick_any;
                beats_left_reg  <= 4'd0;
                incr_mode_reg   <= 1'b0;
                state_reg       <= pick_any ? ARB_OWNED : ARB_IDLE;
                if (pick_any) begin
                    last_ptr_reg <= pick_id;
                end
            end else begin
                beats_left_reg <= beats_left_next;
                incr_mode_reg  <= incr_mode_next;
            end
        end
    end

    assign sel         = sel_reg;
    assign sel_data    = sel_data_reg;
    assign master_id   = master_id_reg;
    assign grant_valid = grant_valid_reg;

endmodule

// File: tb/tb_ahb_arbiter_slave.sv
// Scoreboard bench for the AHB per-slave arbiter: a behavioural model queues
// the expected post-edge outputs, a monitor compares them after every edge.
module tb_ahb_arbiter_slave;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   hreq;
    logic [2*N-1:0] htrans;
    logic [3*N-1:0] hburst;
    logic           hready;
    logic [N-1:0]   sel;
    logic [N-1:0]   sel_data;
    logic [IDW-1:0] master_id;
    logic           grant_valid;

    always #5 clk = ~clk;

    ahb_arbiter_slave #(.CHANNEL_NUM(N)) dut (
        .HCLK        (clk),
        .HRESET      (rst),
        .hreq        (hreq),
        .htrans_in   (htrans),
        .hburst_in   (hburst),
        .hready_in   (hready),
        .sel         (sel),
        .sel_data    (sel_data),
        .master_id   (master_id),
        .grant_valid (grant_valid)
    );

    typedef struct packed {
        logic [N-1:0]   sel;
        logic [N-1:0]   sel_data;
        logic [IDW-1:0] id;
        logic           gv;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: owner index (-1 = nobody), beats still owed, INCR flag.
    int m_owner      = -1;
    int m_data_owner = -1;
    int m_last       = N - 1;
    int m_left       = 0;
    bit m_incr       = 1'b0;

    function automatic int rr_pick(input logic [N-1:0] rq, input int after);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (after + k) % N;
            if (rq[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int o);
        logic [N-1:0] v;
        v = '0;
        if (o >= 0) v[o] = 1'b1;
        return v;
    endfunction

    task automatic model_step(input logic [N-1:0] rq, input logic [2*N-1:0] tr,
                              input logic [3*N-1:0] hb, input logic rdy, input logic rs);
        bit   rel;
        int   t;
        int   b;
        exp_t e;
        rel = 1'b0;
        if (rs) begin
            m_owner = -1; m_data_owner = -1; m_last = N - 1; m_left = 0; m_incr = 1'b0;
        end else if (rdy) begin
            m_data_owner = m_owner;
            if (m_owner < 0) begin
                rel = 1'b1;
            end else begin
                t = int'(tr[2*m_owner +: 2]);
                b = int'(hb[3*m_owner +: 3]);
                if (m_incr && !rq[m_owner] && (t == 0 || t == 2)) rel = 1'b1;
                else if (t == 0) rel = 1'b1;
                else if (t == 2) begin
                    if (b == 0) rel = 1'b1;
                    else if (b == 1) begin m_incr = 1'b1; m_left = 0; end
                    else begin m_incr = 1'b0; m_left = (1 << (b / 2 + 1)) - 1; end
                end else if (t == 3 && !m_incr && m_left > 0) begin
                    m_left--;
                    if (m_left == 0) rel = 1'b1;
                end
            end
            if (rel) begin
                m_owner = rr_pick(rq, m_last);
                if (m_owner >= 0) m_last = m_owner;
                m_left = 0;
                m_incr = 1'b0;
            end
        end
        e.sel      = onehot(m_owner);
        e.sel_data = onehot(m_data_owner);
        e.id       = (m_owner < 0) ? '0 : IDW'(m_owner);
        e.gv       = (m_owner >= 0);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [N-1:0] rq, input logic [2*N-1:0] tr,
                         input logic [3*N-1:0] hb, input logic rdy, input logic rs);
        @(negedge clk);
        hreq   = rq;
        htrans = tr;
        hburst = hb;
        hready = rdy;
        rst    = rs;
        model_step(rq, tr, hb, rdy, rs);
    endtask

    task automatic do_reset();
        drive('0, '0, '0, 1'b1, 1'b1);
        drive('0, '0, '0, 1'b0, 1'b1);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc++;
            total++;
            if (sel !== e.sel || sel_data !== e.sel_data ||
                master_id !== e.id || grant_valid !== e.gv) begin
                bad++;
                $display("FAIL grant cyc=%0d: got sel=%b sel_data=%b id=%0d gv=%b, want sel=%b sel_data=%b id=%0d gv=%b",
                         cyc, sel, sel_data, master_id, grant_valid,
                         e.sel, e.sel_data, e.id, e.gv);
            end else begin
                $display("cyc=%0d sel=%b sel_data=%b id=%0d gv=%b ok",
                         cyc, sel, sel_data, master_id, grant_valid);
            end
        end
    end

    initial begin
        rst = 1'b1; hreq = '0; htrans = '0; hburst = '0; hready = 1'b1;

        // Two masters alternating SINGLE transfers.
        do_reset();
        repeat (5) drive(4'b0011, 8'h0A, '0, 1'b1, 1'b0);

        // Master 0 INCR4 with master 1 waiting.
        do_reset();
        drive(4'b0011, 8'h00, '0, 1'b1, 1'b0);
        drive(4'b0011, 8'h02, 12'h003, 1'b1, 1'b0);
        repeat (3) drive(4'b0011, 8'h03, 12'h003, 1'b1, 1'b0);
        drive(4'b0011, 8'h00, '0, 1'b1, 1'b0);

        // Same INCR4, stalled for two cycles during beat 2.
        do_reset();
        drive(4'b0011, 8'h00, '0, 1'b1, 1'b0);
        drive(4'b0011, 8'h02, 12'h003, 1'b1, 1'b0);
        drive(4'b0011, 8'h03, 12'h003, 1'b1, 1'b0);
        repeat (2) drive(4'b0011, 8'h03, 12'h003, 1'b0, 1'b0);
        repeat (2) drive(4'b0011, 8'h03, 12'h003, 1'b1, 1'b0);
        drive(4'b0011, 8'h00, '0, 1'b1, 1'b0);

        // Master 1 undefined-length INCR with a BUSY, ended by IDLE.
        do_reset();
        drive(4'b0010, 8'h00, '0, 1'b1, 1'b0);
        drive(4'b0011, 8'h08, 12'h008, 1'b1, 1'b0);
        repeat (3) drive(4'b0011, 8'h0C, 12'h008, 1'b1, 1'b0);
        drive(4'b0011, 8'h04, 12'h008, 1'b1, 1'b0);
        repeat (3) drive(4'b0011, 8'h0C, 12'h008, 1'b1, 1'b0);
        drive(4'b0011, 8'h00, '0, 1'b1, 1'b0);
        drive(4'b0011, 8'h00, '0, 1'b1, 1'b0);

        // Reset in the middle of an INCR8, even while stalled.
        do_reset();
        drive(4'b0001, 8'h00, '0, 1'b1, 1'b0);
        drive(4'b0001, 8'h02, 12'h005, 1'b1, 1'b0);
        repeat (4) drive(4'b0001, 8'h03, 12'h005, 1'b1, 1'b0);
        drive(4'b0001, 8'h03, 12'h005, 1'b0, 1'b1);
        repeat (3) drive(4'b0011, 8'h0A, '0, 1'b1, 1'b0);

        // Stray SEQ with no burst outstanding must not underflow.
        do_reset();
        drive(4'b0011, 8'h00, '0, 1'b1, 1'b0);
        repeat (3) drive(4'b0011, 8'h03, '0, 1'b1, 1'b0);
        drive(4'b0011, 8'h02, '0, 1'b1, 1'b0);

        // Sparse requesters 1 and 3, then everyone goes quiet.
        do_reset();
        repeat (4) drive(4'b1010, 8'h88, '0, 1'b1, 1'b0);
        repeat (2) drive(4'b0000, 8'h00, '0, 1'b1, 1'b0);

        // Randomised traffic with stalls and rare resets.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            drive(N'($urandom), (2*N)'($urandom), (3*N)'($urandom),
                  ($urandom_range(0, 4) != 0), ($urandom_range(0, 149) == 0));
        end

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
